surf_dna_seq: RTL and testbench

- Autonomous sequencer and owner of the DNA_PORTE2 device-DNA port in the SURF ID/control wishbone domain.
- On reset release, or on command, it loads the 96-bit DNA, shifts it out serially and caches it in a parallel register.
- Software reads the cache as three 32-bit words instead of bit-banging READ/SHIFT.
- The legacy single-bit register path (ext_*) shares the port through a fixed-priority mux and is locked out while a sequence runs.

---
 rtl/surf_dna_seq.sv | 133 +++++++++++++
 tb/tb_surf_dna_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_dna_seq.sv
// DNA_PORTE2 sequencer: loads, shifts and caches the 96-bit device DNA.
// Legacy single-bit ext path shares the port while the sequencer is idle.
module surf_dna_seq #(
  parameter int DNA_BITS  = 96,
  parameter bit AUTO_READ = 1'b1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [DNA_BITS-1:0] dna_o,
  input  logic [1:0]          word_sel_i,
  output logic [31:0]         word_o,
  input  logic                ext_read_i,
  input  logic                ext_shift_i,
  output logic                ext_blocked_o,
  input  logic                ext_clr_i,
  output logic                dna_read_o,
  output logic                dna_shift_o,
  output logic                dna_din_o,
  input  logic                dna_dout_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [6:0] LAST = 7'(DNA_BITS - 1);

  state_t              state;
  state_t              state_n;
  logic [6:0]          cnt;
  logic [6:0]          cnt_n;
  logic                auto_pend;
  logic [DNA_BITS-1:0] dna_sr;
  logic                go;
  logic                fsm_read;
  logic                fsm_shift;
  logic                port_busy;
  logic                ext_req;
  logic [31:0]         word_n;

  assign busy_o    = (state != S_IDLE);
  assign go        = start_i | auto_pend;
  assign ext_req   = ext_read_i | ext_shift_i;
  assign dna_din_o = dna_dout_i;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE:   if (go) state_n = S_LOAD;
      S_LOAD:   state_n = S_SETTLE;
      S_SETTLE: begin
        state_n = S_SHIFT;
        cnt_n   = '0;
      end
      S_SHIFT: begin
        if (cnt == LAST) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Port strobes are decoded from the next state so the registered
  // outputs line up with the cycle the FSM is actually in.
  always_comb begin
    fsm_read  = (state_n == S_LOAD);
    fsm_shift = (state_n == S_SHIFT) && (cnt_n != LAST);
    port_busy = busy_o | (state_n != S_IDLE);
  end

  always_comb begin
    word_n = '0;
    case (word_sel_i)
      2'd0:    word_n = dna_o[31:0];
      2'd1:    word_n = dna_o[63:32];
      2'd2:    word_n = dna_o[95:64];
      default: word_n = {valid_o, busy_o, ext_blocked_o, 29'b0};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state         <= S_IDLE;
      cnt           <= '0;
      auto_pend     <= AUTO_READ;
      dna_sr        <= '0;
      dna_o         <= '0;
      valid_o       <= 1'b0;
      word_o        <= '0;
      ext_blocked_o <= 1'b0;
      dna_read_o    <= 1'b0;
      dna_shift_o   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      word_o <= word_n;
      if (state == S_IDLE && go) begin
        auto_pend <= 1'b0;
        valid_o   <= 1'b0;
      end
      if (state == S_SHIFT) dna_sr[cnt] <= dna_dout_i;
      if (state == S_DONE) begin
        dna_o   <= dna_sr;
        valid_o <= 1'b1;
      end
      if (port_busy) begin
        dna_read_o  <= fsm_read;
        dna_shift_o <= fsm_shift;
      end else begin
        dna_read_o  <= ext_read_i;
        dna_shift_o <= ext_shift_i;
      end
      if (busy_o && ext_req)
        ext_blocked_o <= 1'b1;
      else if (ext_clr_i)
        ext_blocked_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_surf_dna_seq.sv
// Bench for surf_dna_seq: DNA_PORTE2 port models, scoreboard on valid_o.
// Auto-read and manual-start instances share clock and reset.
module tb_surf_dna_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_start, a_busy, a_valid, a_blk, a_rd, a_sh, a_din, a_dout;
  logic        a_er, a_es, a_clr;
  logic [95:0] a_dna_o;
  logic [1:0]  a_sel;
  logic [31:0] a_word;

  logic        m_start, m_busy, m_valid, m_blk, m_rd, m_sh, m_din, m_dout;
  logic [95:0] m_dna_o;
  logic [1:0]  m_sel;
  logic [31:0] m_word;

  logic [95:0] a_dna, m_dna;
  logic [95:0] a_psr = '0;
  logic [95:0] m_psr = '0;

  int n_vec = 0;
  int n_err = 0;
  int m_act = 0;
  logic [95:0] exp_q[$];

  surf_dna_seq #(.DNA_BITS(96), .AUTO_READ(1'b1)) u_auto (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(a_start),
    .busy_o(a_busy), .valid_o(a_valid), .dna_o(a_dna_o),
    .word_sel_i(a_sel), .word_o(a_word),
    .ext_read_i(a_er), .ext_shift_i(a_es),
    .ext_blocked_o(a_blk), .ext_clr_i(a_clr),
    .dna_read_o(a_rd), .dna_shift_o(a_sh),
    .dna_din_o(a_din), .dna_dout_i(a_dout)
  );

  surf_dna_seq #(.DNA_BITS(96), .AUTO_READ(1'b0)) u_man (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(m_start),
    .busy_o(m_busy), .valid_o(m_valid), .dna_o(m_dna_o),
    .word_sel_i(m_sel), .word_o(m_word),
    .ext_read_i(1'b0), .ext_shift_i(1'b0),
    .ext_blocked_o(m_blk), .ext_clr_i(1'b0),
    .dna_read_o(m_rd), .dna_shift_o(m_sh),
    .dna_din_o(m_din), .dna_dout_i(m_dout)
  );

  // DNA_PORTE2 behaviour: READ loads, SHIFT moves DIN in at the top
  assign a_dout = a_psr[0];
  assign m_dout = m_psr[0];
  always @(posedge clk) begin
    if (a_rd) a_psr <= a_dna;
    else if (a_sh) a_psr <= {a_din, a_psr[95:1]};
    if (m_rd) m_psr <= m_dna;
    else if (m_sh) m_psr <= {m_din, m_psr[95:1]};
  end

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a();
    int i;
    for (i = 0; i < 400; i++) begin
      if (!a_busy && a_valid) break;
      cyc();
    end
    if (i == 400) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_a: timeout busy=%b valid=%b", a_busy, a_valid);
    end
  endtask

  task automatic chk_words(input logic [95:0] d, input logic blk);
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      cyc();
      case (s)
        0: chk("word0", 96'(a_word), 96'(d[31:0]));
        1: chk("word1", 96'(a_word), 96'(d[63:32]));
        2: chk("word2", 96'(a_word), 96'(d[95:64]));
        default: chk("word3", 96'(a_word), 96'({1'b1, 1'b0, blk, 29'b0}));
      endcase
    end
  endtask

  // Issue a start (plus optional ignored starts at busy cycles p1/p2)
  task automatic run_a(input logic [95:0] d, input int p1, input int p2);
    a_dna = d;
    exp_q.push_back(d);
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    for (int c = 2; c < 99; c++) begin
      if (c == p1 || c == p2) a_start = 1'b1;
      cyc();
      a_start = 1'b0;
    end
    wait_a();
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Monitor: one expected DNA per completed sequence, plus its shape
  initial begin : monitor
    logic pb, pv;
    int b_cnt, r_cnt, s_cnt, v_cnt;
    logic [95:0] e;
    pb = 0; pv = 0;
    b_cnt = 0; r_cnt = 0; s_cnt = 0; v_cnt = 0;
    forever begin
      @(negedge clk);
      if (m_rd || m_sh) m_act++;
      if (!rst_n) begin
        pb = 0;
        pv = 0;
      end else begin
        if (a_busy && !pb) begin
          b_cnt = 0; r_cnt = 0; s_cnt = 0; v_cnt = 0;
        end
        if (a_busy) begin
          b_cnt++;
          if (a_rd) r_cnt++;
          if (a_sh) s_cnt++;
        end
        if (!a_valid) v_cnt++;
        if (a_valid && !pv) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: unexpected dna %h", a_dna_o);
          end else begin
            e = exp_q.pop_front();
            chk("sb_dna", a_dna_o, e);
            chk("sb_busy_len", 96'(b_cnt), 96'd99);
            chk("sb_valid_low", 96'(v_cnt), 96'd99);
            chk("sb_reads", 96'(r_cnt), 96'd1);
            chk("sb_shifts", 96'(s_cnt), 96'd95);
          end
        end
        pb = a_busy;
        pv = a_valid;
      end
    end
  end

  initial begin : stim
    int i;
    logic [95:0] d;
    rst_n = 1'b0;
    a_start = 0; a_er = 0; a_es = 0; a_clr = 0; a_sel = 2'd0;
    m_start = 0; m_sel = 2'd3;
    a_dna = 96'hA5A5_0123_4567_89AB_CDEF_F00D;
    m_dna = rnd96();
    repeat (3) cyc();

    chk("rst_busy", 96'(a_busy), 96'd0);
    chk("rst_valid", 96'(a_valid), 96'd0);
    chk("rst_dna", a_dna_o, 96'd0);
    chk("rst_word", 96'(a_word), 96'd0);
    chk("rst_port", 96'({a_blk, a_rd, a_sh}), 96'd0);

    exp_q.push_back(a_dna);
    rst_n = 1'b1;
    wait_a();
    chk_words(a_dna, 1'b0);
    chk("recirc", 96'(a_din), 96'(a_dout));
    chk("man_idle_act", 96'(m_act), 96'd0);
    chk("man_word3_idle", 96'(m_word), 96'd0);

    run_a(a_dna, 5, 50);
    chk_words(a_dna, 1'b0);

    d = rnd96();
    a_dna = d;
    exp_q.push_back(d);
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    repeat (10) cyc();
    a_es = 1'b1;
    cyc();
    a_es = 1'b0;
    a_er = 1'b1;
    cyc();
    a_er = 1'b0;
    wait_a();
    chk("blk_set", 96'(a_blk), 96'd1);
    chk_words(d, 1'b1);
    a_clr = 1'b1;
    cyc();
    a_clr = 1'b0;
    chk("blk_clr", 96'(a_blk), 96'd0);
    a_er = 1'b1;
    cyc();
    a_er = 1'b0;
    chk("ext_rd_hi", 96'(a_rd), 96'd1);
    cyc();
    chk("ext_rd_lo", 96'(a_rd), 96'd0);

    // Abort a sequence partway through the shift phase
    d = rnd96();
    a_dna = d;
    exp_q.push_back(d);
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    repeat (42) cyc();
    chk("pre_rst_sh", 96'(a_sh), 96'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 96'({a_busy, a_valid, a_rd, a_sh}), 96'd0);
    exp_q.delete();
    cyc();
    d = rnd96();
    a_dna = d;
    exp_q.push_back(d);
    rst_n = 1'b1;
    wait_a();
    chk_words(d, 1'b0);

    chk("man_act_pre", 96'(m_act), 96'd0);
    m_start = 1'b1;
    cyc();
    m_start = 1'b0;
    for (i = 0; i < 400; i++) begin
      if (!m_busy && m_valid) break;
      cyc();
    end
    chk("man_done", 96'(i < 400), 96'd1);
    chk("man_dna", m_dna_o, m_dna);
    cyc();
    chk("man_word3", 96'(m_word), 96'(32'h8000_0000));

    for (int r = 0; r < 4; r++) begin
      run_a(rnd96(), int'($urandom_range(2, 98)),
            int'($urandom_range(2, 98)));
      chk_words(a_dna, 1'b0);
    end

    repeat (3) cyc();
    chk("sb_drained", 96'(exp_q.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
